// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : two-requester single-port memory arbiter, burst-limited
//               round-robin with a one-deep read-response pipeline.
// Revision    : 1.0
// ============================================================================
module mem_arbiter #(
    parameter int unsigned BURST_MAX = 4
) (
    input  logic        i_clk,
    input  logic        rst,

    input  logic        i_m0_req,
    input  logic        i_m0_we,
    input  logic [31:0] i_m0_addr,
    input  logic [31:0] i_m0_wdata,
    input  logic [3:0]  i_m0_bmask,
    output logic        o_m0_gnt,
    output logic        o_m0_rvalid,
    output logic [31:0] o_m0_rdata,

    input  logic        i_m1_req,
    input  logic        i_m1_we,
    input  logic [31:0] i_m1_addr,
    input  logic [31:0] i_m1_wdata,
    input  logic [3:0]  i_m1_bmask,
    output logic        o_m1_gnt,
    output logic        o_m1_rvalid,
    output logic [31:0] o_m1_rdata,

    output logic        o_mem_en,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_bmask,
    input  logic [31:0] i_mem_rdata
);

    localparam logic [3:0] C_BURST_MAX = 4'(BURST_MAX);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    state_t     state_q,     state_d;
    logic [3:0] burst_cnt_q, burst_cnt_d;
    logic       last_id_q,   last_id_d;
    logic       pend_vld_q,  pend_vld_d;
    logic       pend_id_q,   pend_id_d;

    logic       gnt0, gnt1;
    logic       own_id, req_own, req_oth;
    logic       sel_we;

    // Owner-relative view lets one branch serve both OWN states.
    assign own_id  = (state_q == ST_OWN1);
    assign req_own = own_id ? i_m1_req : i_m0_req;
    assign req_oth = own_id ? i_m0_req : i_m1_req;

    always_comb begin
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (i_m0_req && i_m1_req) begin
                    gnt0 = last_id_q;
                    gnt1 = ~last_id_q;
                end else begin
                    gnt0 = i_m0_req;
                    gnt1 = i_m1_req;
                end
                if (gnt0 || gnt1) begin
                    state_d     = gnt1 ? ST_OWN1 : ST_OWN0;
                    burst_cnt_d = 4'd1;
                end
            end
            ST_OWN0, ST_OWN1: begin
                if (req_own && ((burst_cnt_q < C_BURST_MAX) || !req_oth)) begin
                    gnt0        = ~own_id;
                    gnt1        = own_id;
                    burst_cnt_d = (burst_cnt_q >= C_BURST_MAX) ? C_BURST_MAX
                                                               : burst_cnt_q + 4'd1;
                end else if (req_oth) begin
                    gnt0        = own_id;
                    gnt1        = ~own_id;
                    state_d     = own_id ? ST_OWN0 : ST_OWN1;
                    burst_cnt_d = 4'd1;
                end else begin
                    state_d     = ST_IDLE;
                    burst_cnt_d = 4'd0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                burst_cnt_d = 4'd0;
            end
        endcase

        // Reset holds every strobe low regardless of requests.
        if (!rst) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    assign last_id_d  = (gnt0 || gnt1) ? gnt1 : last_id_q;
    assign sel_we     = gnt1 ? i_m1_we : i_m0_we;
    assign pend_vld_d = (gnt0 || gnt1) && !sel_we;
    assign pend_id_d  = gnt1;

    always_ff @(posedge i_clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            burst_cnt_q <= 4'd0;
            last_id_q   <= 1'b1;
            pend_vld_q  <= 1'b0;
            pend_id_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            last_id_q   <= last_id_d;
            pend_vld_q  <= pend_vld_d;
            pend_id_q   <= pend_id_d;
        end
    end

    assign o_m0_gnt    = gnt0;
    assign o_m1_gnt    = gnt1;

    assign o_mem_en    = gnt0 | gnt1;
    assign o_mem_we    = o_mem_en & sel_we;
    assign o_mem_addr  = gnt1 ? i_m1_addr  : i_m0_addr;
    assign o_mem_wdata = gnt1 ? i_m1_wdata : i_m0_wdata;
    assign o_mem_bmask = o_mem_en ? (gnt1 ? i_m1_bmask : i_m0_bmask) : 4'd0;

    // Gating with rst drops a response whose read was granted just before reset.
    assign o_m0_rvalid = rst & pend_vld_q & ~pend_id_q;
    assign o_m1_rvalid = rst & pend_vld_q &  pend_id_q;
    assign o_m0_rdata  = o_m0_rvalid ? i_mem_rdata : 32'd0;
    assign o_m1_rdata  = o_m1_rvalid ? i_mem_rdata : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter : directed self-checking bench for mem_arbiter.
// Revision       : 1.0
// ============================================================================
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_bmask, m1_bmask;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_bmask;

    int n_tests = 0;
    int n_fail  = 0;

    mem_arbiter #(.BURST_MAX(4)) dut (
        .i_clk(clk), .rst(rst),
        .i_m0_req(m0_req), .i_m0_we(m0_we), .i_m0_addr(m0_addr),
        .i_m0_wdata(m0_wdata), .i_m0_bmask(m0_bmask),
        .o_m0_gnt(m0_gnt), .o_m0_rvalid(m0_rvalid), .o_m0_rdata(m0_rdata),
        .i_m1_req(m1_req), .i_m1_we(m1_we), .i_m1_addr(m1_addr),
        .i_m1_wdata(m1_wdata), .i_m1_bmask(m1_bmask),
        .o_m1_gnt(m1_gnt), .o_m1_rvalid(m1_rvalid), .o_m1_rdata(m1_rdata),
        .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .o_mem_bmask(mem_bmask), .i_mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1ns after the edge; outputs are sampled 4ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
        chk("mutex", {31'd0, m0_gnt & m1_gnt}, 32'd0);
    endtask

    task automatic drive0(input logic req, input logic we, input logic [31:0] addr,
                          input logic [3:0] bmask);
        m0_req = req; m0_we = we; m0_addr = addr;
        m0_wdata = ~addr; m0_bmask = bmask;
    endtask

    task automatic drive1(input logic req, input logic we, input logic [31:0] addr,
                          input logic [3:0] bmask);
        m1_req = req; m1_we = we; m1_addr = addr;
        m1_wdata = ~addr; m1_bmask = bmask;
    endtask

    initial begin
        logic exp1;
        rst = 1'b0;
        mem_rdata = 32'd0;
        drive0(1'b1, 1'b0, 32'h100, 4'hF);
        drive1(1'b1, 1'b0, 32'h200, 4'hF);
        step();
        settle();
        chk("rst_gnt0", {31'd0, m0_gnt}, 32'd0);
        chk("rst_gnt1", {31'd0, m1_gnt}, 32'd0);
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
        step();

        // First tie goes to m0, reads return one cycle later.
        rst = 1'b1;
        settle();
        chk("tie_gnt0", {31'd0, m0_gnt}, 32'd1);
        chk("tie_gnt1", {31'd0, m1_gnt}, 32'd0);
        chk("tie_addr", mem_addr, 32'h100);
        chk("tie_we", {31'd0, mem_we}, 32'd0);
        step();
        drive0(1'b0, 1'b0, 32'h0, 4'h0);
        mem_rdata = 32'hA5A5_0100;
        settle();
        chk("c1_gnt1", {31'd0, m1_gnt}, 32'd1);
        chk("c1_addr", mem_addr, 32'h200);
        chk("c1_rvalid0", {31'd0, m0_rvalid}, 32'd1);
        chk("c1_rdata0", m0_rdata, 32'hA5A5_0100);
        chk("c1_rvalid1", {31'd0, m1_rvalid}, 32'd0);
        chk("c1_rdata1", m1_rdata, 32'd0);
        step();
        drive1(1'b0, 1'b0, 32'h0, 4'h0);
        mem_rdata = 32'h5A5A_0200;
        settle();
        chk("c2_rvalid1", {31'd0, m1_rvalid}, 32'd1);
        chk("c2_rdata1", m1_rdata, 32'h5A5A_0200);
        chk("c2_rvalid0", {31'd0, m0_rvalid}, 32'd0);
        chk("c2_mem_en", {31'd0, mem_en}, 32'd0);
        chk("c2_bmask", {28'd0, mem_bmask}, 32'd0);
        step();

        // Burst limit: m0 streams writes; m1 wins at 4 and again at 9.
        for (int c = 0; c < 10; c++) begin
            drive0(1'b1, 1'b1, 32'h1000 + c, 4'h3);
            drive1((c >= 1 && c <= 4) || (c >= 6), 1'b1, 32'h2000, 4'hC);
            exp1 = (c == 4) || (c == 9);
            settle();
            chk($sformatf("burst_gnt0_c%0d", c), {31'd0, m0_gnt}, {31'd0, ~exp1});
            chk($sformatf("burst_gnt1_c%0d", c), {31'd0, m1_gnt}, {31'd0, exp1});
            chk($sformatf("burst_addr_c%0d", c), mem_addr, exp1 ? 32'h2000 : 32'h1000 + c);
            chk($sformatf("burst_we_c%0d", c), {31'd0, mem_we}, 32'd1);
            step();
        end

        // Idle return after OWN1, then a lone m1 read.
        drive0(1'b0, 1'b0, 32'h0, 4'h0);
        drive1(1'b0, 1'b0, 32'h0, 4'h0);
        settle();
        chk("idle_mem_en", {31'd0, mem_en}, 32'd0);
        chk("idle_gnt1", {31'd0, m1_gnt}, 32'd0);
        step();
        drive1(1'b1, 1'b0, 32'h300, 4'hF);
        settle();
        chk("idle_m1_gnt", {31'd0, m1_gnt}, 32'd1);
        chk("idle_m1_addr", mem_addr, 32'h300);
        step();

        // Reset the cycle after the read grant swallows its response.
        rst = 1'b0;
        drive0(1'b1, 1'b1, 32'h400, 4'h1);
        drive1(1'b1, 1'b1, 32'h500, 4'h2);
        mem_rdata = 32'hDEAD_BEEF;
        settle();
        chk("rstrd_rvalid1", {31'd0, m1_rvalid}, 32'd0);
        chk("rstrd_rdata1", m1_rdata, 32'd0);
        chk("rstrd_gnt0", {31'd0, m0_gnt}, 32'd0);
        chk("rstrd_gnt1", {31'd0, m1_gnt}, 32'd0);
        chk("rstrd_mem_en", {31'd0, mem_en}, 32'd0);
        step();
        rst = 1'b1;
        settle();
        chk("post_rst_gnt0", {31'd0, m0_gnt}, 32'd1);
        chk("post_rst_rvalid1", {31'd0, m1_rvalid}, 32'd0);
        step();
        drive0(1'b0, 1'b0, 32'h0, 4'h0);
        settle();
        chk("post_rst_gnt1", {31'd0, m1_gnt}, 32'd1);
        step();
        drive1(1'b0, 1'b0, 32'h0, 4'h0);
        settle();
        step();

        // Uncontended writes are never throttled; counter saturates at 4.
        for (int c = 0; c < 20; c++) begin
            drive0(1'b1, 1'b1, 32'h8000 + 4 * c, 4'(c));
            settle();
            chk($sformatf("solo_gnt0_c%0d", c), {31'd0, m0_gnt}, 32'd1);
            chk($sformatf("solo_bmask_c%0d", c), {28'd0, mem_bmask}, 32'(c % 16));
            chk($sformatf("solo_we_c%0d", c), {31'd0, mem_we}, 32'd1);
            chk($sformatf("solo_rvalid_c%0d", c), {31'd0, m0_rvalid}, 32'd0);
            step();
        end
        drive1(1'b1, 1'b1, 32'h9000, 4'h5);
        settle();
        chk("sat_gnt1", {31'd0, m1_gnt}, 32'd1);
        chk("sat_wdata", mem_wdata, ~32'h9000);
        chk("sat_bmask", {28'd0, mem_bmask}, 32'h5);
        step();
        drive0(1'b0, 1'b0, 32'h0, 4'h0);
        drive1(1'b0, 1'b0, 32'h0, 4'h0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
